universal_shift_register: RTL and testbench
===========================================

# universal_shift_register

Parametrised multi-lane shift register with a command interface. It supports parallel load, clear, logical and arithmetic shifts, and rotates in both directions. Each command can repeat its operation for a programmable number of single-lane steps, driven by an internal burst counter. It is the general-purpose successor to the single-bit bidirectional shifter and is used for serialisers, delay lines and lane-realignment stages.

## Interface
- WIDTH, 8, bits per lane (≥1)
- DEPTH, 8, number of lanes (≥2)
- COUNT_W, 8, width of the burst repeat count

- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  3  operation code (see Operation)
- cmd_count  in  COUNT_W  extra repetitions; a shift op performs cmd_count+1 steps
- par_in  in  DEPTH*WIDTH  parallel load data; lane i = bits [i*WIDTH +: WIDTH]
- ser_in  in  WIDTH  serial lane input, sampled on every shift step
- abort  in  1  terminate a running burst
- par_out  out  DEPTH*WIDTH  register contents
- ser_out_hi  out  WIDTH  lane DEPTH-1 of par_out (combinational)
- ser_out_lo  out  WIDTH  lane 0 of par_out (combinational)
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse after a command's final update

## Operation
- Op codes:
  - 0 NOP: no register change.
  - 1 LOAD: par_out <= par_in.
  - 2 SHL: lane i <= lane i-1; lane 0 <= ser_in.
  - 3 SHR: lane i <= lane i+1; lane DEPTH-1 <= ser_in.
  - 4 ROL: lane 0 <= lane DEPTH-1, others as SHL.
  - 5 ROR: lane DEPTH-1 <= lane 0, others as SHR.
  - 6 ASR: as SHR, but lane DEPTH-1 keeps its value; ser_in is ignored.
  - 7 CLEAR: all lanes <= 0.
- NOP, LOAD and CLEAR are single-step; cmd_count is ignored for these ops.
- Shift ops (2–6) perform cmd_count+1 single-lane steps, one per cycle. Op and count are latched at acceptance.
- FSM:
  - IDLE: cmd_ready=1.
  - On acceptance, step 1 is applied at the accept edge. If the op is a shift op and cmd_count>0, go to RUN with rem<=cmd_count; otherwise stay in IDLE and set done<=1.
  - RUN: busy=1, cmd_ready=0. Each edge applies one step and sets rem<=rem-1. When rem==1 at an edge, that step is applied, the FSM goes to IDLE and done<=1.
- abort while in RUN: no step is applied that edge, the FSM goes to IDLE, done stays 0, and par_out keeps its partial result. abort in IDLE is ignored.
- cmd_valid while busy is not accepted; the upstream must hold it until cmd_ready.
- Reset has priority over everything: par_out=0, FSM=IDLE, busy=0, done=0, cmd_ready=0 while reset is high.

## Timing
- Accept at edge t: par_out reflects step 1 after edge t.
- A burst of N=cmd_count+1 steps:
  - final update at edge t+N-1
  - busy high for cycles t+1 … t+N-1 (N-1 cycles)
  - done high for exactly the cycle after edge t+N-1
  - cmd_ready returns high in the same cycle as done
- Back-to-back commands: a new command may be accepted in the done cycle, giving zero bubble between bursts.
- ser_in is sampled at each step edge; the upstream updates it once per cycle during a burst.
- ser_out_hi and ser_out_lo have zero latency from par_out.
- cmd_count = 2^COUNT_W−1 gives 2^COUNT_W steps; there is no wrap, and rem is COUNT_W bits wide.

## Structure
- Package universal_shift_pkg: op-code localparams (OP_NOP … OP_CLEAR), FSM state encoding (ST_IDLE, ST_RUN), and the lane-slice helper function.
- Sub-module usr_step_datapath: purely combinational next-value function of (cur, par_in, ser_in, op) for one step. The top level holds the FSM, the rem counter, done/busy and the state register.

## Test plan
- Reset: assert reset for 2 cycles with cmd_valid=1 -> par_out=0, busy=0, done=0, cmd_ready=0; cmd_ready=1 the cycle after reset drops.
- LOAD, then single-step shifts: WIDTH=8, DEPTH=4, LOAD 0x44332211, then SHL count=0 with ser_in=0xAA -> 0x332211AA and done pulses once; next command ASR count=0 -> 0x33332211.
- Burst rotate: LOAD 0x44332211, then ROR count=3 -> busy for 3 cycles, par_out=0x44332211 after the 4th step, done on cycle t+4, cmd_ready low t+1..t+3.
- Abort: SHR count=5 on 0x44332211 with ser_in=0; assert abort in the 3rd busy cycle -> exactly 3 steps applied, par_out=0x00000044, done stays 0, IDLE next cycle.
- Reset mid-burst: ROL count=10, assert reset at the 4th step -> par_out=0, busy=0, no done pulse, a fresh command is accepted after reset.
- Back-to-back and max count: COUNT_W=4, SHL count=15 immediately followed by CLEAR -> exactly 16 steps, CLEAR accepted in the done cycle, par_out=0 one edge later.

Source files
------------

// File: rtl/universal_shift_pkg.sv
// Shared op codes, FSM encoding and lane helpers for the universal shift register.
package universal_shift_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_SHL   = 3'd2;
    localparam logic [2:0] OP_SHR   = 3'd3;
    localparam logic [2:0] OP_ROL   = 3'd4;
    localparam logic [2:0] OP_ROR   = 3'd5;
    localparam logic [2:0] OP_ASR   = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_RUN
    } state_e;

    // Bit offset of a lane within the packed lane vector.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

    // Only shift/rotate ops honour the burst count.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op >= OP_SHL) && (op <= OP_ASR);
    endfunction

endpackage

// File: rtl/universal_shift_register_step_datapath.sv
// Combinational single-step next-value function for the lane register.
module usr_step_datapath
    import universal_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic [DEPTH*WIDTH-1:0] cur_i,
    input  logic [DEPTH*WIDTH-1:0] par_in_i,
    input  logic [WIDTH-1:0]       ser_in_i,
    input  logic [2:0]             op_i,
    output logic [DEPTH*WIDTH-1:0] next_o
);

    localparam int unsigned TopLsb = lane_lsb(DEPTH - 1, WIDTH);

    logic [WIDTH-1:0] lane_lo;
    logic [WIDTH-1:0] lane_hi;

    assign lane_lo = cur_i[WIDTH-1:0];
    assign lane_hi = cur_i[TopLsb +: WIDTH];

    always_comb begin
        next_o = cur_i;
        unique case (op_i)
            OP_NOP:   next_o = cur_i;
            OP_LOAD:  next_o = par_in_i;
            OP_SHL:   next_o = {cur_i[TopLsb-1:0], ser_in_i};
            OP_ROL:   next_o = {cur_i[TopLsb-1:0], lane_hi};
            OP_SHR:   next_o = {ser_in_i, cur_i[DEPTH*WIDTH-1:WIDTH]};
            OP_ROR:   next_o = {lane_lo, cur_i[DEPTH*WIDTH-1:WIDTH]};
            // Sign-extend at lane granularity: the top lane replicates downward.
            OP_ASR:   next_o = {lane_hi, cur_i[DEPTH*WIDTH-1:WIDTH]};
            OP_CLEAR: next_o = '0;
            default:  next_o = cur_i;
        endcase
    end

endmodule

// File: rtl/universal_shift_register.sv
// Multi-lane shift register with command handshake, burst repeat counter and abort.
module universal_shift_register
    import universal_shift_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned COUNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [COUNT_W-1:0]     cmd_count,
    input  logic [DEPTH*WIDTH-1:0] par_in,
    input  logic [WIDTH-1:0]       ser_in,
    input  logic                   abort,
    output logic [DEPTH*WIDTH-1:0] par_out,
    output logic [WIDTH-1:0]       ser_out_hi,
    output logic [WIDTH-1:0]       ser_out_lo,
    output logic                   busy,
    output logic                   done
);

    state_e                 state_q, state_d;
    logic [COUNT_W-1:0]     rem_q, rem_d;
    logic [2:0]             op_q, op_d;
    logic                   done_q, done_d;
    logic [DEPTH*WIDTH-1:0] data_q, data_d;

    logic [2:0]             step_op;
    logic [DEPTH*WIDTH-1:0] step_next;

    usr_step_datapath #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_datapath (
        .cur_i    (data_q),
        .par_in_i (par_in),
        .ser_in_i (ser_in),
        .op_i     (step_op),
        .next_o   (step_next)
    );

    assign cmd_ready  = (state_q == ST_IDLE) && !reset;
    assign busy       = (state_q == ST_RUN);
    assign done       = done_q;
    assign par_out    = data_q;
    assign ser_out_lo = data_q[WIDTH-1:0];
    assign ser_out_hi = data_q[lane_lsb(DEPTH - 1, WIDTH) +: WIDTH];

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        op_d    = op_q;
        done_d  = 1'b0;
        data_d  = data_q;
        step_op = OP_NOP;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    step_op = cmd_op;
                    data_d  = step_next;
                    op_d    = cmd_op;
                    if (is_shift_op(cmd_op) && (cmd_count != '0)) begin
                        state_d = ST_RUN;
                        rem_d   = cmd_count;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // Abort drops the step for this edge and leaves the partial result.
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    step_op = op_q;
                    data_d  = step_next;
                    rem_d   = rem_q - COUNT_W'(1);
                    if (rem_q == COUNT_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            op_q    <= OP_NOP;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed scoreboard bench for universal_shift_register (WIDTH=8, DEPTH=4, COUNT_W=4).
module tb_universal_shift_register;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned COUNT_W = 4;

    localparam logic [2:0] NOP   = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] SHL   = 3'd2;
    localparam logic [2:0] SHR   = 3'd3;
    localparam logic [2:0] ROL   = 3'd4;
    localparam logic [2:0] ROR   = 3'd5;
    localparam logic [2:0] ASR   = 3'd6;
    localparam logic [2:0] CLEAR = 3'd7;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [2:0]             cmd_op;
    logic [COUNT_W-1:0]     cmd_count;
    logic [DEPTH*WIDTH-1:0] par_in;
    logic [WIDTH-1:0]       ser_in;
    logic                   abort;
    logic [DEPTH*WIDTH-1:0] par_out;
    logic [WIDTH-1:0]       ser_out_hi;
    logic [WIDTH-1:0]       ser_out_lo;
    logic                   busy;
    logic                   done;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    universal_shift_register #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_count  (cmd_count),
        .par_in     (par_in),
        .ser_in     (ser_in),
        .abort      (abort),
        .par_out    (par_out),
        .ser_out_hi (ser_out_hi),
        .ser_out_lo (ser_out_lo),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: observed %h, scoreboard empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    // Waits (bounded) for cmd_ready, then lets the accept edge pass.
    task automatic issue(input logic [2:0] op, input logic [COUNT_W-1:0] cnt,
                         input logic [31:0] pin, input logic [WIDTH-1:0] sin);
        int waited;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = cnt;
        par_in    = pin;
        ser_in    = sin;
        waited    = 0;
        while (!cmd_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: cmd_ready stayed low, op %0d", op);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = LOAD;
        cmd_count = '0;
        par_in    = 32'h1234_5678;
        ser_in    = '0;
        abort     = 1'b0;
        tick();
        tick();
        push(32'h0); check("reset_par_out", par_out);
        push(32'h0); check("reset_busy", {31'b0, busy});
        push(32'h0); check("reset_done", {31'b0, done});
        push(32'h0); check("reset_cmd_ready", {31'b0, cmd_ready});
        reset     = 1'b0;
        cmd_valid = 1'b0;
        #1;
        push(32'h1); check("ready_after_reset", {31'b0, cmd_ready});

        // Load then single-step shifts
        issue(LOAD, 4'd3, 32'h4433_2211, 8'h00);
        push(32'h4433_2211); check("load_par_out", par_out);
        push(32'h1); check("load_done", {31'b0, done});
        issue(SHL, 4'd0, 32'hDEAD_BEEF, 8'hAA);
        push(32'h3322_11AA); check("shl1_par_out", par_out);
        push(32'h1); check("shl1_done", {31'b0, done});
        push(32'h0); check("shl1_busy", {31'b0, busy});
        push(32'hAA); check("shl1_ser_lo", {24'b0, ser_out_lo});
        push(32'h33); check("shl1_ser_hi", {24'b0, ser_out_hi});
        tick();
        push(32'h0); check("shl1_done_once", {31'b0, done});
        issue(ASR, 4'd0, 32'hDEAD_BEEF, 8'h55);
        push(32'h3333_2211); check("asr1_par_out", par_out);

        // Burst rotate right, 4 steps
        issue(LOAD, 4'd0, 32'h4433_2211, 8'h00);
        issue(ROR, 4'd3, 32'h0, 8'h00);
        push(32'h1144_3322); check("ror_step1", par_out);
        for (int i = 1; i <= 3; i++) begin
            push(32'h1); check("ror_busy", {31'b0, busy});
            push(32'h0); check("ror_ready_low", {31'b0, cmd_ready});
            push(32'h0); check("ror_no_early_done", {31'b0, done});
            tick();
        end
        push(32'h4433_2211); check("ror_par_out", par_out);
        push(32'h1); check("ror_done", {31'b0, done});
        push(32'h1); check("ror_ready_back", {31'b0, cmd_ready});
        push(32'h0); check("ror_busy_off", {31'b0, busy});

        // Abort during SHR burst
        issue(LOAD, 4'd0, 32'h4433_2211, 8'h00);
        issue(SHR, 4'd5, 32'h0, 8'h00);
        push(32'h1); check("abort_busy1", {31'b0, busy});
        tick();
        tick();
        push(32'h1); check("abort_busy3", {31'b0, busy});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        push(32'h0000_0044); check("abort_par_out", par_out);
        push(32'h0); check("abort_done", {31'b0, done});
        push(32'h0); check("abort_busy_off", {31'b0, busy});
        push(32'h1); check("abort_idle_ready", {31'b0, cmd_ready});
        tick();
        push(32'h0); check("abort_done_later", {31'b0, done});
        push(32'h0000_0044); check("abort_hold", par_out);

        // Reset in the middle of a ROL burst
        issue(LOAD, 4'd0, 32'h4433_2211, 8'h00);
        issue(ROL, 4'd10, 32'h0, 8'h00);
        push(32'h3322_1144); check("rol_step1", par_out);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        push(32'h0); check("midreset_par_out", par_out);
        push(32'h0); check("midreset_busy", {31'b0, busy});
        push(32'h0); check("midreset_done", {31'b0, done});
        tick();
        push(32'h0); check("midreset_no_done", {31'b0, done});
        issue(LOAD, 4'd0, 32'hCAFE_BABE, 8'h00);
        push(32'hCAFE_BABE); check("post_reset_load", par_out);

        // Max-count SHL with changing ser_in, then CLEAR in the done cycle
        issue(SHL, 4'd15, 32'h0, 8'h01);
        for (int k = 2; k <= 16; k++) begin
            push(32'h1); check("max_busy", {31'b0, busy});
            ser_in = 8'(k);
            tick();
        end
        push(32'h0D0E_0F10); check("max_par_out", par_out);
        push(32'h1); check("max_done", {31'b0, done});
        push(32'h1); check("max_ready", {31'b0, cmd_ready});
        cmd_valid = 1'b1;
        cmd_op    = CLEAR;
        cmd_count = 4'd9;
        tick();
        cmd_valid = 1'b0;
        push(32'h0); check("b2b_clear_par_out", par_out);
        push(32'h1); check("b2b_clear_done", {31'b0, done});
        push(32'h0); check("b2b_clear_busy", {31'b0, busy});
        tick();
        push(32'h0); check("final_done_low", {31'b0, done});

        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_leftover: %0d entries, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Unused op codes kept for readability of the directed steps.
    logic [2:0] unused_ops;
    assign unused_ops = NOP ^ ROR ^ ROL ^ ASR;

endmodule
